// File: rtl/uart_line_buffer.sv
// uart_line_buffer
// Sits between uart_rx and uart_tx in the echo path. Received bytes are
// collected until the terminator arrives or the buffer is full. The whole line
// is then replayed to uart_tx one byte at a time using the DV/Done handshake.
//
// Build option: define LINE_BUFFER_REVERSE_EN to replay the line last-in
// first-out (terminator first). Without it the line replays in arrival order.
//
// Handshake contract (single statement for checker binding):
//   i_Rx_DV   : one-cycle strobe. The byte is stored only in FILL. In LAUNCH or
//               WAIT it is discarded and o_Drop pulses in the next cycle.
//   o_Tx_DV   : one-cycle strobe. o_Tx_Byte is valid from that cycle and holds
//               until the next strobe. A new strobe is issued only after an
//               i_Tx_Done has been accepted in WAIT.
//   i_Tx_Done : one-cycle strobe. It is acted on only in WAIT and ignored in
//               FILL and LAUNCH.
// o_Debug = {i_Tx_Active, fsm_state}, where FILL=0, LAUNCH=1 and WAIT=2.
module uart_line_buffer #(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] TERMINATOR = 8'h0D
) (
    input  logic                    i_Clock,
    input  logic                    i_Rst_n,
    input  logic                    i_Rx_DV,
    input  logic [7:0]              i_Rx_Byte,
    input  logic                    i_Tx_Active,
    input  logic                    i_Tx_Done,
    output logic                    o_Tx_DV,
    output logic [7:0]              o_Tx_Byte,
    output logic [$clog2(DEPTH):0]  o_Count,
    output logic                    o_Drop,
    output logic [2:0]              o_Debug
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr;
    logic [PTR_W-1:0] rd;
    logic [CNT_W-1:0] count;

    // A stored byte ends the line if it is the terminator or it fills the last slot.
    logic line_end;
    // count is already zero after the final launch, so a Done seen now ends the replay.
    logic line_sent;

    // Strobes decoded from the current state. They drive the datapath register updates.
    logic do_store;
    logic do_close;
    logic do_launch;
    logic do_rewind;
    logic do_drop;

    assign line_end  = (i_Rx_Byte == TERMINATOR) || (count == CNT_W'(DEPTH - 1));
    assign line_sent = (count == '0);

    // State register. Asynchronous reset returns the buffer to collecting.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. LAUNCH always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if (i_Rx_DV && line_end) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_Tx_Done) begin
                    state_next = line_sent ? S_FILL : S_LAUNCH;
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    // Output decode. Each strobe is true only in the state that owns the action.
    always_comb begin
        do_store  = 1'b0;
        do_close  = 1'b0;
        do_launch = 1'b0;
        do_rewind = 1'b0;
        do_drop   = i_Rx_DV && (state != S_FILL);
        case (state)
            S_FILL: begin
                do_store = i_Rx_DV;
                do_close = i_Rx_DV && line_end;
            end
            S_LAUNCH: begin
                do_launch = 1'b1;
            end
            S_WAIT: begin
                do_rewind = i_Tx_Done && line_sent;
            end
            default: begin
                do_drop = 1'b0;
            end
        endcase
    end

    // Line storage. The contents are not reset; count says which entries are live.
    always_ff @(posedge i_Clock) begin
        if (do_store) begin
            mem[wr] <= i_Rx_Byte;
        end
    end

    // Pointers, occupancy and the registered transmit-side outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr        <= '0;
            rd        <= '0;
            count     <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            o_Drop    <= 1'b0;
        end else begin
            o_Drop  <= do_drop;
            o_Tx_DV <= do_launch;

            if (do_store) begin
                wr    <= wr + PTR_W'(1);
                count <= count + CNT_W'(1);
            end

            if (do_close) begin
`ifdef LINE_BUFFER_REVERSE_EN
                // The byte just written is the first one to go out.
                rd <= wr;
`else
                rd <= '0;
`endif
            end

            if (do_launch) begin
                o_Tx_Byte <= mem[rd];
                count     <= count - CNT_W'(1);
`ifdef LINE_BUFFER_REVERSE_EN
                rd <= rd - PTR_W'(1);
`else
                rd <= rd + PTR_W'(1);
`endif
            end

            // The next line starts at slot 0 once the last byte is confirmed sent.
            if (do_rewind) begin
                wr <= '0;
            end
        end
    end

    assign o_Count = count;
    assign o_Debug = {i_Tx_Active, state};

endmodule

// File: doc/uart_line_buffer.md
# uart_line_buffer

Byte buffer between `uart_rx` and `uart_tx` in the UART echo path. Collects received bytes until a terminator byte arrives or the buffer fills, then replays the whole line to `uart_tx` one byte at a time using the transmitter's DV/Done handshake. Bytes that arrive while a line is being replayed are dropped and flagged.

## Interface
- `DEPTH`, 16: buffer capacity in bytes; power of two, 2..256.
- `TERMINATOR`, 8'h0D: byte value that closes a line; the terminator itself is stored and replayed.

Ports:
- `i_Clock`  in  1  system clock (12 MHz on IceStick).
- `i_Rst_n`  in  1  asynchronous active-low reset.
- `i_Rx_DV`  in  1  one-cycle pulse from `uart_rx`: `i_Rx_Byte` is valid.
- `i_Rx_Byte`  in  8  received byte.
- `i_Tx_Active`  in  1  `uart_tx` busy; monitoring only, no control effect.
- `i_Tx_Done`  in  1  one-cycle pulse from `uart_tx` at end of a byte.
- `o_Tx_DV`  out  1  one-cycle start pulse to `uart_tx`.
- `o_Tx_Byte`  out  8  byte to transmit; stable from the `o_Tx_DV` cycle until the next `o_Tx_DV`.
- `o_Count`  out  $clog2(DEPTH)+1  bytes currently held.
- `o_Drop`  out  1  one-cycle pulse per received byte that was discarded.

## Operation
- Storage: `DEPTH` x 8 register array; write pointer `wr`, read pointer `rd`, counter `count` (width `$clog2(DEPTH)+1`).
- States: FILL, LAUNCH, WAIT.
- FILL:
  - On `i_Rx_DV`: `mem[wr] <= i_Rx_Byte`, `wr++`, `count++`.
  - If the byte equals `TERMINATOR`, or `count` becomes `DEPTH`, go to LAUNCH and set `rd` to the first byte to send (see Configuration).
  - `i_Tx_Done` is ignored in FILL.
- LAUNCH (one cycle): `o_Tx_Byte <= mem[rd]`, `o_Tx_DV <= 1`, advance `rd`, `count--`, go to WAIT.
- WAIT:
  - `o_Tx_DV <= 0`.
  - On `i_Tx_Done`: if `count == 0`, go to FILL with `wr <= 0`; otherwise go to LAUNCH.
- Any `i_Rx_DV` in LAUNCH or WAIT is not stored; `o_Drop` pulses in the following cycle.
- Line length 1 (a lone terminator) is valid and replays one byte.
- Pointer arithmetic wraps modulo `DEPTH`. `count` never exceeds `DEPTH` and never underflows.

## Timing
- Reset values: state FILL, `wr`/`rd`/`count` 0, `o_Tx_DV` 0, `o_Tx_Byte` 8'h00, `o_Drop` 0, `o_Count` 0. Array contents are not reset.
- Reset mid-replay aborts immediately. `uart_tx` may finish its current byte; the resulting `i_Tx_Done` lands in FILL and is ignored.
- Latency: `i_Rx_DV` carrying the closing byte is sampled at edge N. The state is LAUNCH during cycle N+1, and `o_Tx_DV` is high during cycle N+2.
- Inter-byte gap: `i_Tx_Done` at edge M puts the state in LAUNCH during M+1; the next `o_Tx_DV` is high during cycle M+2.
- `o_Tx_DV` is never high for more than one cycle. It is never asserted twice without an intervening `i_Tx_Done`.
- `i_Rx_DV` and `i_Tx_Done` in the same cycle: in FILL, store the byte; in WAIT, process Done and drop the byte.
- `o_Count` equals `count` registered, so it reflects the current contents.

## Configuration
- `LINE_BUFFER_REVERSE_EN` defined: replay in LIFO order. `rd` starts at `wr-1` (after the final write) and decrements, so the terminator is sent first.
- Undefined: FIFO order. `rd` starts at 0 and increments.

## Test plan
- FIFO build, `DEPTH`=4: rx 8'h41, 8'h42, 8'h0D -> `o_Tx_Byte` sequence 41, 42, 0D. Each `o_Tx_DV` is a single cycle, 2 cycles after the preceding trigger.
- `LINE_BUFFER_REVERSE_EN` build, `DEPTH`=4: rx 31, 32, 33, 34 (no terminator) -> flush on full; tx 34, 33, 32, 31; `o_Count` steps 4,3,2,1,0.
- Drop: during WAIT, rx 8'h55 -> `o_Drop` pulses once; the line content is unchanged and 55 is never transmitted.
- Lone terminator: rx 0D in FILL -> exactly one tx of 0D, then back in FILL with `o_Count`=0.
- Simultaneous: `i_Rx_DV` (8'h77) and `i_Tx_Done` in the same WAIT cycle -> next byte launched and `o_Drop`=1. In FILL, the same coincidence stores 77 and does not launch.
- Reset: assert `i_Rst_n`=0 between the 2nd and 3rd tx of a 4-byte line -> all outputs reset at once. A subsequent rx 41, 0D replays exactly 41, 0D.
